// File: rtl/regfile_wport_arbiter.sv
// Write-port arbiter for the register file: grants one of two writeback sources
// per cycle and tracks long-latency destinations in a busy scoreboard.
module regfile_wport_arbiter #(
  parameter  int AW    = 5,
  parameter  int DW    = 32,
  parameter  int RR_EN = 1,
  localparam int NREG  = 2**AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [DW-1:0]   wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [DW-1:0]   wb1_data,
  output logic            wb1_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   rd_addr_A,
  input  logic [AW-1:0]   rd_addr_B,
  input  logic [AW-1:0]   rd_addr_C,
  output logic [AW-1:0]   reg_W_addr,
  output logic [DW-1:0]   wdata,
  output logic            reg_we,
  output logic            stall,
  output logic [NREG-1:0] busy_vec,
  output logic            err
);

  logic            last_grant_q, last_grant_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  logic            grant0, grant1, transfer;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (wb0_valid && wb1_valid) begin
      if (RR_EN != 0) begin
        // last_grant_q==1 means req1 went last, so req0 takes the tie.
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = wb0_valid;
      grant1 = wb1_valid;
    end
    transfer = grant0 | grant1;

    gnt_addr = '0;
    gnt_data = '0;
    if (grant0) begin
      gnt_addr = wb0_addr;
      gnt_data = wb0_data;
    end else if (grant1) begin
      gnt_addr = wb1_addr;
      gnt_data = wb1_data;
    end

    last_grant_d = transfer ? grant1 : last_grant_q;
  end

  assign wb0_ready  = grant0;
  assign wb1_ready  = grant1;
  assign reg_W_addr = gnt_addr;
  assign wdata      = gnt_data;
  assign reg_we     = transfer && (gnt_addr != '0);

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (transfer && gnt_addr == AW'(r)) busy_d[r] = 1'b0;
      // Issue after clear: a new op to the same register keeps it pending.
      if (iss_valid && iss_addr == AW'(r)) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;

    err_d = err_q;
    if (iss_valid && iss_addr != '0 && busy_q[iss_addr] &&
        !(transfer && gnt_addr == iss_addr))
      err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      busy_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign busy_vec = busy_q;
  assign err      = err_q;
  assign stall    = (rd_addr_A != '0 && busy_q[rd_addr_A]) ||
                    (rd_addr_B != '0 && busy_q[rd_addr_B]) ||
                    (rd_addr_C != '0 && busy_q[rd_addr_C]);

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: a cycle-by-cycle vector table plus
// hand sequences for reset with random inputs and reset in mid-operation.
module tb_regfile_wport_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb0_valid, wb1_valid, iss_valid;
  logic [AW-1:0] wb0_addr, wb1_addr, iss_addr, rd_addr_A, rd_addr_B, rd_addr_C;
  logic [DW-1:0] wb0_data, wb1_data;

  logic          wb0_ready, wb1_ready, reg_we, stall, err;
  logic [AW-1:0] reg_W_addr;
  logic [DW-1:0] wdata;
  logic [31:0]   busy_vec;

  logic          fp_wb0_ready, fp_wb1_ready, fp_reg_we, fp_stall, fp_err;
  logic [AW-1:0] fp_reg_W_addr;
  logic [DW-1:0] fp_wdata;
  logic [31:0]   fp_busy_vec;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(.AW(AW), .DW(DW), .RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B), .rd_addr_C(rd_addr_C),
    .reg_W_addr(reg_W_addr), .wdata(wdata), .reg_we(reg_we),
    .stall(stall), .busy_vec(busy_vec), .err(err)
  );

  regfile_wport_arbiter #(.AW(AW), .DW(DW), .RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(fp_wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(fp_wb1_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B), .rd_addr_C(rd_addr_C),
    .reg_W_addr(fp_reg_W_addr), .wdata(fp_wdata), .reg_we(fp_reg_we),
    .stall(fp_stall), .busy_vec(fp_busy_vec), .err(fp_err)
  );

  typedef struct {
    logic          w0v; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
    logic          w1v; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
    logic          iv;  logic [AW-1:0] ia;
    logic [AW-1:0] ra, rb, rc;
    logic          e_r0, e_r1, e_we;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    logic          e_st;
    logic [31:0]   e_busy;
    logic          e_err;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb0_valid = v.w0v; wb0_addr = v.w0a; wb0_data = v.w0d;
    wb1_valid = v.w1v; wb1_addr = v.w1a; wb1_data = v.w1d;
    iss_valid = v.iv;  iss_addr = v.ia;
    rd_addr_A = v.ra;  rd_addr_B = v.rb; rd_addr_C = v.rc;
  endtask

  task automatic idle();
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    iss_valid = 1'b0; iss_addr = '0;
    rd_addr_A = '0;   rd_addr_B = '0; rd_addr_C = '0;
  endtask

  initial begin
    // Fields: wb0 v/a/d, wb1 v/a/d, iss v/a, rd A/B/C | ready0, ready1, we, waddr, wdata, stall, busy, err
    // Round-robin from reset: req0 first, then alternate.
    vecs[0]  = '{1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 1'b0,5'd0, 5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,5'd3,32'h11,1'b0,32'h0,1'b0};
    vecs[1]  = '{1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 1'b0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b1,1'b1,5'd4,32'h22,1'b0,32'h0,1'b0};
    vecs[2]  = '{1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 1'b0,5'd0, 5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,5'd3,32'h11,1'b0,32'h0,1'b0};
    vecs[3]  = '{1'b1,5'd3,32'h11, 1'b1,5'd4,32'h22, 1'b0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b1,1'b1,5'd4,32'h22,1'b0,32'h0,1'b0};
    // Scoreboard set, stall through the clearing cycle, gone after it.
    vecs[4]  = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd5, 5'd0,5'd5,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,32'h0,1'b0};
    vecs[5]  = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd0,5'd5,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b1,32'h20,1'b0};
    vecs[6]  = '{1'b0,5'd0,32'h0,  1'b1,5'd5,32'h55, 1'b0,5'd0, 5'd0,5'd5,5'd0, 1'b0,1'b1,1'b1,5'd5,32'h55,1'b1,32'h20,1'b0};
    vecs[7]  = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd0,5'd5,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,32'h0,1'b0};
    // Same-cycle issue and clear on r7: set wins, no error.
    vecs[8]  = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd7, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,32'h0,1'b0};
    vecs[9]  = '{1'b0,5'd0,32'h0,  1'b1,5'd7,32'h77, 1'b1,5'd7, 5'd0,5'd0,5'd0, 1'b0,1'b1,1'b1,5'd7,32'h77,1'b0,32'h80,1'b0};
    vecs[10] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,32'h80,1'b0};
    vecs[11] = '{1'b1,5'd7,32'h70, 1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,5'd7,32'h70,1'b0,32'h80,1'b0};
    vecs[12] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,32'h0,1'b0};
    // Register 0: handshake completes without a write; issue to r0 ignored.
    vecs[13] = '{1'b1,5'd0,32'hAB, 1'b0,5'd0,32'h0,  1'b1,5'd0, 5'd0,5'd0,5'd0, 1'b1,1'b0,1'b0,5'd0,32'hAB,1'b0,32'h0,1'b0};
    vecs[14] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,32'h0,1'b0};
    // Double issue to r9 raises sticky err.
    vecs[15] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd9, 5'd9,5'd0,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,32'h0,1'b0};
    vecs[16] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd9, 5'd9,5'd0,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b1,32'h200,1'b0};
    vecs[17] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd0,5'd0,5'd9, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b1,32'h200,1'b1};
    vecs[18] = '{1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0, 1'b0,32'h200,1'b1};

    // Reset held over several edges with random inputs.
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      wb0_valid = 1'($urandom); wb0_addr = AW'($urandom); wb0_data = $urandom;
      wb1_valid = 1'($urandom); wb1_addr = AW'($urandom); wb1_data = $urandom;
      iss_valid = 1'($urandom); iss_addr = AW'($urandom);
      rd_addr_A = AW'($urandom); rd_addr_B = AW'($urandom); rd_addr_C = AW'($urandom);
      @(negedge clk);
      #1;
      check("rst_busy", busy_vec, 32'h0);
      check("rst_err", {31'b0, err}, 32'h0);
      check("rst_stall", {31'b0, stall}, 32'h0);
    end

    // Release reset and run the vector table, one cycle per entry.
    for (int i = 0; i < NVEC; i++) begin
      if (i != 0) @(negedge clk);
      rst = 1'b0;
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_ready0", i), {31'b0, wb0_ready},  {31'b0, vecs[i].e_r0});
      check($sformatf("v%0d_ready1", i), {31'b0, wb1_ready},  {31'b0, vecs[i].e_r1});
      check($sformatf("v%0d_we", i),     {31'b0, reg_we},     {31'b0, vecs[i].e_we});
      check($sformatf("v%0d_waddr", i),  {27'b0, reg_W_addr}, {27'b0, vecs[i].e_wa});
      check($sformatf("v%0d_wdata", i),  wdata,               vecs[i].e_wd);
      check($sformatf("v%0d_stall", i),  {31'b0, stall},      {31'b0, vecs[i].e_st});
      check($sformatf("v%0d_busy", i),   busy_vec,            vecs[i].e_busy);
      check($sformatf("v%0d_err", i),    {31'b0, err},        {31'b0, vecs[i].e_err});
      // Fixed-priority instance: req0 wins whenever it is valid.
      check($sformatf("v%0d_fp_ready0", i), {31'b0, fp_wb0_ready}, {31'b0, vecs[i].w0v});
      check($sformatf("v%0d_fp_ready1", i), {31'b0, fp_wb1_ready},
            {31'b0, vecs[i].w1v & ~vecs[i].w0v});
    end

    // err stays set across more idle cycles.
    @(negedge clk);
    idle();
    #1;
    check("err_sticky", {31'b0, err}, 32'h1);

    // Reset mid-operation clears state at once, without waiting for an edge.
    @(negedge clk);
    wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h99;
    rd_addr_A = 5'd9;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy_vec, 32'h0);
    check("midrst_err", {31'b0, err}, 32'h0);
    check("midrst_stall", {31'b0, stall}, 32'h0);

    // After release, the first tie goes to req0 again.
    @(negedge clk);
    rst = 1'b0;
    wb0_valid = 1'b1; wb0_addr = 5'd2; wb0_data = 32'h12;
    #1;
    check("post_rst_ready0", {31'b0, wb0_ready}, 32'h1);
    check("post_rst_ready1", {31'b0, wb1_ready}, 32'h0);
    check("post_rst_waddr", {27'b0, reg_W_addr}, 32'h2);
    @(negedge clk);
    #1;
    check("post_rst_alt_ready1", {31'b0, wb1_ready}, 32'h1);
    check("post_rst_err", {31'b0, err}, 32'h0);
    check("post_rst_busy", busy_vec, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
